// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit core: fetch FSM state encoding,
// instruction field bit positions and the opcodes that steer sequencing.
package cpu16_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int DST_HI = 11;
  localparam int DST_LO = 10;
  localparam int SRC_HI = 9;
  localparam int SRC_LO = 8;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JZ  = 4'h5;
  localparam logic [3:0] OP_JNZ = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/fetch16.sv
// fetch16 - instruction fetch / sequencing stage of the 16-bit core.
// Holds the PC, performs a req/ack read from instruction memory, keeps the
// fetched word in the IR, splits it into fields for control16 and commits
// control16's pc_next/pc_we/halt once per instruction.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   run_en                  allow starting a new fetch
//   imem_req/addr/ack/rdata instruction memory handshake (rdata valid with ack)
//   pc, opcode, reg_dst,    address and decoded fields of the word in the IR
//   reg_src, imm8
//   exec_valid              one-cycle strobe, control16 outputs committed
//   pc_next, pc_we, halt    from control16, sampled only in EXEC
//   halted                  sticky stop flag after HLT
//   retired                 saturating count of committed instructions
//
// state | meaning
// FETCH | idle; start a request when run_en=1
// WAIT  | request outstanding; address held until ack
// EXEC  | IR valid, commit control16 results (one cycle)
// HALT  | stopped by HLT; only reset leaves
module fetch16
  import cpu16_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              IW       = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [IW-1:0]    imem_rdata,
  output logic [PC_W-1:0]  pc,
  output logic [3:0]       opcode,
  output logic [1:0]       reg_dst,
  output logic [1:0]       reg_src,
  output logic [7:0]       imm8,
  output logic             exec_valid,
  input  logic [PC_W-1:0]  pc_next,
  input  logic             pc_we,
  input  logic             halt,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PC_W-1:0]  r_pc;
  logic [IW-1:0]    r_ir;
  logic             r_halted;
  logic [CNT_W-1:0] r_retired;
  logic             w_req;
  logic             w_exec;
  logic             w_ir_load;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_exec      = 1'b0;
    w_ir_load   = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (run_en) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        // run_en is deliberately ignored here: a started request is never withdrawn
        w_req = 1'b1;
        if (imem_ack) begin
          w_ir_load   = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_exec      = 1'b1;
        w_state_nxt = halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_ir      <= '0;
      r_halted  <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_ir_load) r_ir <= imem_rdata;
      if (w_exec) begin
        if (halt) r_halted <= 1'b1;
        else if (pc_we) r_pc <= pc_next;
        if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign exec_valid = w_exec;
  assign halted     = r_halted;
  assign retired    = r_retired;

  assign opcode  = r_ir[OP_HI:OP_LO];
  assign reg_dst = r_ir[DST_HI:DST_LO];
  assign reg_src = r_ir[SRC_HI:SRC_LO];
  assign imm8    = r_ir[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_fetch16.sv
module tb_fetch16;

  logic        clk = 1'b0;
  logic        rst_n, run_en;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr, pc, imm8, pc_next;
  logic [15:0] imem_rdata;
  logic [3:0]  opcode;
  logic [1:0]  reg_dst, reg_src;
  logic        exec_valid, pc_we, halt, halted;
  logic [15:0] retired;

  logic        rst2_n, run_en2;
  logic        imem_req2, imem_ack2;
  logic [7:0]  imem_addr2, pc2, imm8_2, pc_next2;
  logic [15:0] imem_rdata2;
  logic [3:0]  opcode2;
  logic [1:0]  reg_dst2, reg_src2;
  logic        exec_valid2, pc_we2, halt2, halted2;
  logic [1:0]  retired2;

  always #5 clk = ~clk;

  fetch16 dut (
    .clk(clk), .rst_n(rst_n), .run_en(run_en),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pc(pc), .opcode(opcode), .reg_dst(reg_dst), .reg_src(reg_src), .imm8(imm8),
    .exec_valid(exec_valid), .pc_next(pc_next), .pc_we(pc_we), .halt(halt),
    .halted(halted), .retired(retired)
  );

  fetch16 #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .run_en(run_en2),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_ack(imem_ack2), .imem_rdata(imem_rdata2),
    .pc(pc2), .opcode(opcode2), .reg_dst(reg_dst2), .reg_src(reg_src2), .imm8(imm8_2),
    .exec_valid(exec_valid2), .pc_next(pc_next2), .pc_we(pc_we2), .halt(halt2),
    .halted(halted2), .retired(retired2)
  );

  // Stand-in for control16: HLT halts, JMP loads imm8, op 3 leaves pc alone, else pc+1.
  function automatic logic [9:0] ctl(input logic [3:0] op, input logic [7:0] imm, input logic [7:0] p);
    logic [7:0] inc;
    inc = p + 8'd1;
    case (op)
      4'hF:    return {1'b1, 1'b0, p};
      4'h4:    return {1'b0, 1'b1, imm};
      4'h3:    return {1'b0, 1'b0, inc};
      default: return {1'b0, 1'b1, inc};
    endcase
  endfunction

  assign {halt, pc_we, pc_next}    = ctl(opcode, imm8, pc);
  assign {halt2, pc_we2, pc_next2} = ctl(opcode2, imm8_2, pc2);

  // Memory models with programmable wait states.
  logic [15:0] mem  [256];
  logic [15:0] mem2 [256];
  int          mem_wait;
  int          wcnt;

  always @(posedge clk) begin
    if (!imem_req) wcnt <= 0;
    else if (!imem_ack) wcnt <= wcnt + 1;
  end
  assign imem_ack    = imem_req && (wcnt == mem_wait);
  assign imem_rdata  = mem[imem_addr];
  assign imem_ack2   = imem_req2;
  assign imem_rdata2 = mem2[imem_addr2];

  // Observers
  int          cyc;
  int          req_cnt, req2_cnt;
  logic [7:0]  exec_pcs [$];
  int          exec_cyc [$];
  logic [15:0] exec_irs [$];
  logic [7:0]  ack_addrs [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (exec_valid) begin
      exec_pcs.push_back(pc);
      exec_cyc.push_back(cyc);
      exec_irs.push_back({opcode, reg_dst, reg_src, imm8});
    end
    if (imem_req) req_cnt++;
    if (imem_req && imem_ack) ack_addrs.push_back(imem_addr);
    if (imem_req2) req2_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    exec_pcs.delete();
    exec_cyc.delete();
    exec_irs.delete();
    ack_addrs.delete();
    req_cnt = 0;
  endtask

  initial begin
    int         reqc;
    logic       addr_ok;
    logic [7:0] a0, a1, a2, a3;
    int         d;

    cyc = 0; wcnt = 0; req_cnt = 0; req2_cnt = 0;
    rst_n = 1'b0; run_en = 1'b0; rst2_n = 1'b0; run_en2 = 1'b0;
    mem_wait = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 16'h0000;
      mem2[i] = 16'h0000;
    end

    // ---- reset state
    tick(); tick();
    check("rst_req", imem_req, 1'b0);
    check("rst_exec", exec_valid, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_retired", retired, 16'h0);
    check("rst_pc", pc, 8'h00);
    check("rst_ir", {opcode, reg_dst, reg_src, imm8}, 16'h0000);

    // ---- run_en=0 in FETCH: no request
    rst_n = 1'b1;
    clear_obs();
    repeat (5) tick();
    check("no_req_run_off", req_cnt, 0);

    // ---- zero-wait program MOVI; HLT
    mem[0] = 16'h1105;
    mem[1] = 16'hF000;
    run_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (halted) break;
    end
    check("p1_halted", halted, 1'b1);
    check("p1_nexec", exec_pcs.size(), 2);
    if (exec_pcs.size() == 2) begin
      check("p1_exec_pc0", exec_pcs[0], 8'h00);
      check("p1_exec_pc1", exec_pcs[1], 8'h01);
      check("p1_ir0", exec_irs[0], 16'h1105);
      check("p1_fields0", {exec_irs[0][15:12], exec_irs[0][11:10], exec_irs[0][9:8], exec_irs[0][7:0]},
            {4'h1, 2'd0, 2'd1, 8'h05});
      d = exec_cyc[1] - exec_cyc[0];
      check("p1_cpi", d, 3);
    end
    check("p1_retired", retired, 16'd2);
    check("p1_pc", pc, 8'h01);
    check("p1_opcode", opcode, 4'hF);

    // ---- halted: run_en toggling ignored
    reqc = req_cnt;
    for (int i = 0; i < 10; i++) begin
      run_en = ~run_en;
      tick();
    end
    check("halt_no_req", req_cnt, reqc);
    check("halt_sticky", halted, 1'b1);
    check("halt_retired", retired, 16'd2);

    // ---- 3 wait states, run_en dropped during WAIT, op 3 keeps pc
    rst_n = 1'b0; run_en = 1'b0;
    tick();
    rst_n = 1'b1;
    mem[0] = 16'h3000;
    mem_wait = 3;
    clear_obs();
    run_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req) break;
    end
    check("w3_req_seen", imem_req, 1'b1);
    run_en = 1'b0;
    reqc = 0;
    addr_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        reqc++;
        if (imem_addr !== 8'h00) addr_ok = 1'b0;
      end
      if (exec_valid) break;
      tick();
    end
    check("w3_exec", exec_valid, 1'b1);
    check("w3_req_cycles", reqc, 4);
    check("w3_addr_stable", addr_ok, 1'b1);
    check("w3_one_load", ack_addrs.size(), 1);
    repeat (10) tick();
    check("w3_parked_no_req", req_cnt, 4);
    check("w3_pc_hold", pc, 8'h00);
    check("w3_retired", retired, 16'd1);
    check("w3_opcode", opcode, 4'h3);

    // ---- JMP and PC wrap
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mem[0]    = 16'h40F0;
    mem[8'hF0] = 16'h40FF;
    mem[8'hFF] = 16'h0000;
    mem_wait = 0;
    clear_obs();
    run_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ack_addrs.size() >= 4) break;
    end
    check("jmp_nacks", ack_addrs.size(), 4);
    if (ack_addrs.size() >= 4) begin
      a0 = ack_addrs[0]; a1 = ack_addrs[1]; a2 = ack_addrs[2]; a3 = ack_addrs[3];
      check("jmp_addr0", a0, 8'h00);
      check("jmp_target", a1, 8'hF0);
      check("jmp_addr2", a2, 8'hFF);
      check("wrap_addr", a3, 8'h00);
    end

    // ---- reset pulsed mid-WAIT
    tick();
    mem_wait = 5;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req) break;
    end
    check("mid_req", imem_req, 1'b1);
    check("mid_addr", imem_addr, 8'hF0);
    check("mid_retired_pre", retired, 16'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_req", imem_req, 1'b0);
    check("rstw_pc", pc, 8'h00);
    check("rstw_retired", retired, 16'd0);
    check("rstw_ir", {opcode, reg_dst, reg_src, imm8}, 16'h0000);
    check("rstw_exec", exec_valid, 1'b0);
    run_en = 1'b0;
    tick();
    rst_n = 1'b1;

    // ---- CNT_W=2: 5 NOPs then HLT, retired saturates at 3
    for (int i = 0; i < 5; i++) mem2[i] = 16'h0000;
    mem2[5] = 16'hF000;
    rst2_n = 1'b1;
    run_en2 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (halted2) break;
    end
    check("sat_halted", halted2, 1'b1);
    check("sat_retired", retired2, 2'd3);
    check("sat_pc", pc2, 8'h05);
    reqc = req2_cnt;
    for (int i = 0; i < 10; i++) begin
      run_en2 = ~run_en2;
      tick();
    end
    check("sat_halt_no_req", req2_cnt, reqc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
